// File: rtl/alarm_clock.sv
// 24-hour BCD real-time clock with a 1 Hz prescaler and a single hh:mm alarm
// that latches on the rising edge of a time match until stopped or disabled.
module alarm_clock #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic       Ghadi,
  input  logic       Reset,
  input  logic [1:0] Hours_Ki_Tenth_digit_IN,
  input  logic [3:0] Hours_Ki_Ones_digit_IN,
  input  logic [3:0] Mins_Ki_Tenth_digit_IN,
  input  logic [3:0] Mins_Ki_Ones_digit_IN,
  input  logic       Load_Samay,
  input  logic       Load_Alarm,
  input  logic       Alarm_Band,
  input  logic       Alarm_Chalu,
  output logic       Alarm,
  output logic [1:0] Hours_Ki_Tenth_digit_OUT,
  output logic [3:0] Hours_Ki_Ones_digit_OUT,
  output logic [3:0] Mins_Ki_Tenth_digit_OUT,
  output logic [3:0] Mins_Ki_Ones_digit_OUT,
  output logic [3:0] Secs_Ki_Tenth_digit_OUT,
  output logic [3:0] Secs_Ki_Ones_digit_OUT
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    hour_tens;
  logic [3:0]    hour_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0]    alarm_hour_tens;
  logic [3:0]    alarm_hour_ones, alarm_min_tens, alarm_min_ones;
  logic          tick, inputs_valid, load_time, load_alarm;
  logic          sec_carry, min_carry, match, match_prev;

  assign tick = (prescaler == PRESC_LAST);

  // A load is only honoured when the requested hh:mm is a legal 24-hour time
  assign inputs_valid =
    ((Hours_Ki_Tenth_digit_IN < 2'd2 && Hours_Ki_Ones_digit_IN <= 4'd9) ||
     (Hours_Ki_Tenth_digit_IN == 2'd2 && Hours_Ki_Ones_digit_IN <= 4'd3)) &&
    (Mins_Ki_Tenth_digit_IN <= 4'd5) && (Mins_Ki_Ones_digit_IN <= 4'd9);

  assign load_time  = Load_Samay && inputs_valid;
  assign load_alarm = Load_Alarm && inputs_valid;

  assign sec_carry = (sec_ones == 4'd9) && (sec_tens == 4'd5);
  assign min_carry = sec_carry && (min_ones == 4'd9) && (min_tens == 4'd5);

  assign match = ({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} ==
                  {alarm_hour_tens, alarm_hour_ones, alarm_min_tens, alarm_min_ones, 8'h00});

  always_ff @(posedge Ghadi or negedge Reset) begin
    if (!Reset) begin
      prescaler <= '0;
    end else if (load_time || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge Ghadi or negedge Reset) begin
    if (!Reset) begin
      hour_tens <= '0;
      hour_ones <= '0;
      min_tens  <= '0;
      min_ones  <= '0;
      sec_tens  <= '0;
      sec_ones  <= '0;
    end else if (load_time) begin
      hour_tens <= Hours_Ki_Tenth_digit_IN;
      hour_ones <= Hours_Ki_Ones_digit_IN;
      min_tens  <= Mins_Ki_Tenth_digit_IN;
      min_ones  <= Mins_Ki_Ones_digit_IN;
      sec_tens  <= '0;
      sec_ones  <= '0;
    end else if (tick) begin
      sec_ones <= (sec_ones == 4'd9) ? 4'd0 : sec_ones + 4'd1;
      if (sec_ones == 4'd9)
        sec_tens <= (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
      if (sec_carry)
        min_ones <= (min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1;
      if (sec_carry && min_ones == 4'd9)
        min_tens <= (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
      // Hours wrap at 23 rather than at a BCD digit boundary
      if (min_carry) begin
        if (hour_tens == 2'd2 && hour_ones == 4'd3) begin
          hour_tens <= '0;
          hour_ones <= '0;
        end else if (hour_ones == 4'd9) begin
          hour_tens <= hour_tens + 2'd1;
          hour_ones <= '0;
        end else begin
          hour_ones <= hour_ones + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Ghadi or negedge Reset) begin
    if (!Reset) begin
      alarm_hour_tens <= '0;
      alarm_hour_ones <= '0;
      alarm_min_tens  <= '0;
      alarm_min_ones  <= '0;
    end else if (load_alarm) begin
      alarm_hour_tens <= Hours_Ki_Tenth_digit_IN;
      alarm_hour_ones <= Hours_Ki_Ones_digit_IN;
      alarm_min_tens  <= Mins_Ki_Tenth_digit_IN;
      alarm_min_ones  <= Mins_Ki_Ones_digit_IN;
    end
  end

  // Fire only on a rising match so a stopped alarm stays quiet for the rest of the window
  always_ff @(posedge Ghadi or negedge Reset) begin
    if (!Reset) begin
      Alarm      <= 1'b0;
      match_prev <= 1'b0;
    end else begin
      match_prev <= match;
      if (Alarm_Band || !Alarm_Chalu)
        Alarm <= 1'b0;
      else if (match && !match_prev)
        Alarm <= 1'b1;
    end
  end

  assign Hours_Ki_Tenth_digit_OUT = hour_tens;
  assign Hours_Ki_Ones_digit_OUT  = hour_ones;
  assign Mins_Ki_Tenth_digit_OUT  = min_tens;
  assign Mins_Ki_Ones_digit_OUT   = min_ones;
  assign Secs_Ki_Tenth_digit_OUT  = sec_tens;
  assign Secs_Ki_Ones_digit_OUT   = sec_ones;

endmodule

// File: tb/tb_alarm_clock.sv
// Table-driven bench for alarm_clock: each record drives the controls, runs a
// number of clock cycles and compares hh:mm:ss and Alarm against hand-computed values.
module tb_alarm_clock;

  logic       Ghadi = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] Hours_Ki_Tenth_digit_IN = '0;
  logic [3:0] Hours_Ki_Ones_digit_IN = '0;
  logic [3:0] Mins_Ki_Tenth_digit_IN = '0;
  logic [3:0] Mins_Ki_Ones_digit_IN = '0;
  logic       Load_Samay = 1'b0;
  logic       Load_Alarm = 1'b0;
  logic       Alarm_Band = 1'b0;
  logic       Alarm_Chalu = 1'b0;
  logic       Alarm;
  logic [1:0] Hours_Ki_Tenth_digit_OUT;
  logic [3:0] Hours_Ki_Ones_digit_OUT, Mins_Ki_Tenth_digit_OUT, Mins_Ki_Ones_digit_OUT;
  logic [3:0] Secs_Ki_Tenth_digit_OUT, Secs_Ki_Ones_digit_OUT;

  typedef struct {
    logic        rst_n;
    logic        ld_time;
    logic        ld_alarm;
    logic        band;
    logic        chalu;
    logic [7:0]  hh;
    logic [7:0]  mm;
    int          cycles;
    logic [23:0] exp_time;
    logic        exp_alarm;
  } vec_t;

  vec_t vecs[$];
  int   vectors_applied = 0;
  int   miscompares = 0;

  alarm_clock #(.TICKS_PER_SEC(10)) dut (
    .Ghadi(Ghadi),
    .Reset(Reset),
    .Hours_Ki_Tenth_digit_IN(Hours_Ki_Tenth_digit_IN),
    .Hours_Ki_Ones_digit_IN(Hours_Ki_Ones_digit_IN),
    .Mins_Ki_Tenth_digit_IN(Mins_Ki_Tenth_digit_IN),
    .Mins_Ki_Ones_digit_IN(Mins_Ki_Ones_digit_IN),
    .Load_Samay(Load_Samay),
    .Load_Alarm(Load_Alarm),
    .Alarm_Band(Alarm_Band),
    .Alarm_Chalu(Alarm_Chalu),
    .Alarm(Alarm),
    .Hours_Ki_Tenth_digit_OUT(Hours_Ki_Tenth_digit_OUT),
    .Hours_Ki_Ones_digit_OUT(Hours_Ki_Ones_digit_OUT),
    .Mins_Ki_Tenth_digit_OUT(Mins_Ki_Tenth_digit_OUT),
    .Mins_Ki_Ones_digit_OUT(Mins_Ki_Ones_digit_OUT),
    .Secs_Ki_Tenth_digit_OUT(Secs_Ki_Tenth_digit_OUT),
    .Secs_Ki_Ones_digit_OUT(Secs_Ki_Ones_digit_OUT)
  );

  always #5 Ghadi = ~Ghadi;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add(input logic rst_n, input logic ld_time, input logic ld_alarm,
                     input logic band, input logic chalu, input logic [7:0] hh,
                     input logic [7:0] mm, input int cycles, input logic [23:0] exp_time,
                     input logic exp_alarm);
    vec_t v;
    v.rst_n = rst_n;  v.ld_time = ld_time;  v.ld_alarm = ld_alarm;
    v.band = band;    v.chalu = chalu;      v.hh = hh;  v.mm = mm;
    v.cycles = cycles; v.exp_time = exp_time; v.exp_alarm = exp_alarm;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    Reset = v.rst_n;
    Load_Samay = v.ld_time;
    Load_Alarm = v.ld_alarm;
    Alarm_Band = v.band;
    Alarm_Chalu = v.chalu;
    Hours_Ki_Tenth_digit_IN = v.hh[5:4];
    Hours_Ki_Ones_digit_IN = v.hh[3:0];
    Mins_Ki_Tenth_digit_IN = v.mm[7:4];
    Mins_Ki_Ones_digit_IN = v.mm[3:0];
    repeat (v.cycles) @(posedge Ghadi);
    #1;
  endtask

  task automatic check_output(input string name, input logic [23:0] exp_time,
                              input logic exp_alarm);
    logic [23:0] act_time;
    act_time = {2'b00, Hours_Ki_Tenth_digit_OUT, Hours_Ki_Ones_digit_OUT,
                Mins_Ki_Tenth_digit_OUT, Mins_Ki_Ones_digit_OUT,
                Secs_Ki_Tenth_digit_OUT, Secs_Ki_Ones_digit_OUT};
    vectors_applied++;
    if (act_time !== exp_time || Alarm !== exp_alarm) begin
      miscompares++;
      $display("[TB] FAIL %s: got time %h alarm %b, expected time %h alarm %b",
               name, act_time, Alarm, exp_time, exp_alarm);
    end
  endtask

  initial begin
    //  rst ldT ldA band chalu  hh     mm    cyc   exp_time    alarm
    add(0, 0, 0, 0, 0, 8'h00, 8'h00,   3, 24'h000000, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00,   9, 24'h000000, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00,   1, 24'h000001, 0);
    add(1, 1, 0, 0, 0, 8'h10, 8'h19,   1, 24'h101900, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00, 599, 24'h101959, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00,   1, 24'h102000, 0);
    add(1, 1, 0, 0, 0, 8'h23, 8'h59,   1, 24'h235900, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00, 590, 24'h235959, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00,  10, 24'h000000, 0);
    add(1, 1, 0, 0, 0, 8'h09, 8'h59,   1, 24'h095900, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00, 590, 24'h095959, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00,  10, 24'h100000, 0);
    add(1, 1, 0, 0, 0, 8'h24, 8'h00,   1, 24'h100000, 0);
    add(1, 1, 0, 0, 0, 8'h10, 8'h60,   1, 24'h100000, 0);
    add(1, 1, 0, 0, 0, 8'h1A, 8'h00,   1, 24'h100000, 0);
    add(1, 0, 1, 0, 1, 8'h10, 8'h20,   1, 24'h100000, 0);
    add(1, 1, 0, 0, 1, 8'h10, 8'h19,   1, 24'h101900, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00, 599, 24'h101959, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   1, 24'h102000, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   1, 24'h102000, 1);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,  50, 24'h102005, 1);
    add(1, 0, 0, 1, 1, 8'h00, 8'h00,   1, 24'h102005, 0);
    add(1, 1, 0, 0, 1, 8'h10, 8'h20,   1, 24'h102000, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   1, 24'h102000, 1);
    add(1, 0, 0, 1, 1, 8'h00, 8'h00,   1, 24'h102000, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   3, 24'h102000, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   5, 24'h102001, 0);
    add(1, 1, 0, 0, 1, 8'h10, 8'h20,   1, 24'h102000, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   1, 24'h102000, 1);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00,   1, 24'h102000, 0);
    add(1, 1, 0, 0, 0, 8'h10, 8'h19,   1, 24'h101900, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00, 600, 24'h102000, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00,   2, 24'h102000, 0);
    add(1, 1, 0, 0, 1, 8'h10, 8'h19,   1, 24'h101900, 0);
    add(1, 0, 1, 0, 1, 8'h24, 8'h00,   1, 24'h101900, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00, 598, 24'h101959, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   1, 24'h102000, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   1, 24'h102000, 1);
    add(1, 0, 0, 1, 1, 8'h00, 8'h00,  10, 24'h102001, 0);
    add(1, 1, 1, 0, 1, 8'h08, 8'h30,   1, 24'h083000, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   1, 24'h083000, 1);
    add(0, 1, 1, 0, 1, 8'h08, 8'h30,   0, 24'h000000, 0);
    add(0, 1, 1, 0, 1, 8'h08, 8'h30,   2, 24'h000000, 0);
    add(1, 0, 0, 0, 1, 8'h00, 8'h00,   1, 24'h000000, 1);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].exp_time, vecs[i].exp_alarm);
    end

    // Held load freezes the time at hh:mm:00 and keeps the prescaler cleared
    Load_Samay = 1'b1;
    Alarm_Chalu = 1'b0;
    Hours_Ki_Tenth_digit_IN = 2'd1;
    Hours_Ki_Ones_digit_IN = 4'd2;
    Mins_Ki_Tenth_digit_IN = 4'd3;
    Mins_Ki_Ones_digit_IN = 4'd4;
    for (int c = 0; c < 25; c++) begin
      @(posedge Ghadi);
      #1;
      if (c % 6 == 0) check_output($sformatf("hold%0d", c), 24'h123400, 1'b0);
    end
    Load_Samay = 1'b0;
    repeat (9) @(posedge Ghadi);
    #1;
    check_output("after_hold9", 24'h123400, 1'b0);
    @(posedge Ghadi);
    #1;
    check_output("after_hold10", 24'h123401, 1'b0);

    // Mid-cycle reset with a pending load must clear immediately
    Load_Samay = 1'b1;
    @(posedge Ghadi);
    #2;
    Reset = 1'b0;
    #1;
    check_output("async_reset", 24'h000000, 1'b0);
    @(posedge Ghadi);
    #1;
    Load_Samay = 1'b0;
    Reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_clock.md
Name: alarm_clock

Overview:
- 24-hour BCD real-time clock with one programmable alarm (hh:mm).
- Ghadi is a fast system clock; an internal prescaler derives a 1 Hz seconds tick from it.
- Outputs the current time as six BCD digits plus an alarm output that latches on match until stopped.
- Sits between user controls (digit switches, load/stop/enable buttons) and a display driver / buzzer.

Parameters:
- TICKS_PER_SEC, default 10: number of Ghadi cycles per seconds increment; must be ≥ 1.

Ports:
- Ghadi  in  1  system clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-low reset
- Hours_Ki_Tenth_digit_IN  in  2  hours tens digit to load (0–2)
- Hours_Ki_Ones_digit_IN  in  4  hours ones digit to load (BCD)
- Mins_Ki_Tenth_digit_IN  in  4  minutes tens digit to load (0–5)
- Mins_Ki_Ones_digit_IN  in  4  minutes ones digit to load (BCD)
- Load_Samay  in  1  level; load the input digits as the current time
- Load_Alarm  in  1  level; load the input digits as the alarm time
- Alarm_Band  in  1  level; stop/clear the alarm
- Alarm_Chalu  in  1  level; alarm enable
- Alarm  out  1  registered alarm output
- Hours_Ki_Tenth_digit_OUT  out  2  current hours tens
- Hours_Ki_Ones_digit_OUT  out  4  current hours ones
- Mins_Ki_Tenth_digit_OUT  out  4  current minutes tens
- Mins_Ki_Ones_digit_OUT  out  4  current minutes ones
- Secs_Ki_Tenth_digit_OUT  out  4  current seconds tens (0–5)
- Secs_Ki_Ones_digit_OUT  out  4  current seconds ones

Behaviour:
- Reset low (asynchronous): time = 00:00:00, alarm time = 00:00, prescaler = 0, Alarm = 0, match history = 0. Outputs reflect this immediately.
- Digit outputs are driven directly from the time registers; there is no added latency.
- Input validity: loaded hh must be ≤ 23 and mm ≤ 59 with all digits valid BCD. An invalid load request is ignored entirely; registers are unchanged.
- Prescaler counts 0 .. TICKS_PER_SEC-1. The seconds tick fires on the cycle it equals TICKS_PER_SEC-1, and the prescaler then wraps to 0.
- Time advance on a tick, cascaded in BCD:
  - secs ones 9 → 0 with carry; secs tens 5 → 0 with carry.
  - Minutes follow the same rule as seconds.
  - Hours: 09 → 10, 19 → 20, 23 → 00.
  - Full wrap: 23:59:59 → 00:00:00.
- Load_Samay high (valid inputs): on each cycle, time = input hh:mm:00 and the prescaler is cleared. It overrides counting while held, so the time is frozen at hh:mm:00.
- Load_Alarm high (valid inputs): alarm hh:mm = inputs. This is independent of and may coincide with Load_Samay; both take effect in the same cycle.
- match = (current time == alarm hh:mm:00). A match_prev register holds the previous cycle's match.
- Alarm output priority, evaluated each cycle:
  1. Alarm_Band = 1 or Alarm_Chalu = 0 → Alarm <= 0.
  2. Otherwise, match && !match_prev → Alarm <= 1, asserted one cycle after the time registers reach the match.
  3. Otherwise → hold.
- Alarm stays latched beyond the matching second or minute until stopped or disabled.
- After a stop, the alarm does not re-fire within the same match window. It re-arms automatically once match drops.
- A match created by Load_Samay or Load_Alarm counts as a rising match.
- Reset mid-operation clears everything immediately, regardless of any pending loads.

Test Plan:
- Reset low for 3 cycles, then release → outputs 0,0,0,0,0,0 and Alarm = 0. After TICKS_PER_SEC cycles, seconds = 01.
- Load_Samay with 1,0,1,9 for one cycle → 10:19:00. After 60×TICKS_PER_SEC cycles → 10:20:00.
- Load_Samay 2,3,5,9, then run 60 seconds → 23:59:59 → 00:00:00 with all digits rolling over; also verify 09:59:59 → 10:00:00.
- Load_Samay 10:19, Load_Alarm 10:20, Alarm_Chalu = 1, run to 10:20:00 → Alarm rises one cycle later and stays high at 10:20:05. Alarm_Band = 1 → Alarm = 0 next cycle. Release Alarm_Band during 10:20:00 → Alarm stays 0.
- Alarm_Chalu = 0 while passing the alarm time → Alarm stays 0. Load_Samay with 2,4,0,0 or minutes tens 6 → time unchanged.
- Assert Reset while Alarm = 1 and Load_Samay is high → immediate 00:00:00 and Alarm = 0.
